// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx
//   Serial pattern transmitter. When a start request is accepted it latches a
//   WIDTH-bit pattern and a repeat count. It then shifts the pattern out
//   MSB-first, one bit per clock, repeat_n_i+1 times, with GAP_CYC idle cycles
//   between repetitions. A one-cycle done pulse marks the end of the transfer.
//
// Ports
//   clk_i         clock, rising edge
//   reset_ni      asynchronous active-low reset
//   start_i       transfer request, sampled only while idle
//   pat_sel_i     0 = built-in PATTERN, 1 = pat_in_i
//   pat_in_i      runtime pattern, latched on an accepted start
//   repeat_n_i    extra repetitions, latched on an accepted start
//   dout_o        serial data, 0 whenever dout_valid_o is low
//   dout_valid_o  dout_o carries a pattern bit this cycle
//   frame_o       high with the MSB of each repetition
//   busy_o        transfer in progress
//   done_o        one-cycle pulse after the last bit
//
// State | meaning
// ------+-----------------------------------------------------------
// IDLE  | no transfer; waiting for start_i (this includes the done cycle)
// SHIFT | presenting one pattern bit per cycle, MSB first
// GAP   | idle spacing between repetitions, lasts GAP_CYC cycles

module seq_pattern_tx #(
  parameter int                WIDTH   = 4,
  parameter logic [WIDTH-1:0]  PATTERN = 4'b1011,
  parameter int                CNT_W   = 4,
  parameter int                GAP_CYC = 1
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  logic             pat_sel_i,
  input  logic [WIDTH-1:0] pat_in_i,
  input  logic [CNT_W-1:0] repeat_n_i,
  output logic             dout_o,
  output logic             dout_valid_o,
  output logic             frame_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LOAD = (GAP_CYC > 0) ? 4'(GAP_CYC - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;

  logic dout_q, dout_d;
  logic valid_q, valid_d;
  logic frame_q, frame_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic [WIDTH-1:0] pat_sel_val;

  assign pat_sel_val = pat_sel_i ? pat_in_i : PATTERN;

  // State and datapath registers
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      pat_q     <= '0;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
      gap_cnt_q <= '0;
      dout_q    <= 1'b0;
      valid_q   <= 1'b0;
      frame_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      pat_q     <= pat_d;
      bit_cnt_q <= bit_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      frame_q   <= frame_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next state and datapath. bit_cnt counts down the bits still to follow the
  // one currently on dout; the shift register rotates so its MSB is always
  // the bit about to be presented.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    pat_d     = pat_q;
    bit_cnt_d = bit_cnt_q;
    rep_cnt_d = rep_cnt_q;
    gap_cnt_d = gap_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          pat_d     = pat_sel_val;
          shreg_d   = pat_sel_val;
          bit_cnt_d = BIT_LAST;
          rep_cnt_d = repeat_n_i;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_q != '0) begin
          shreg_d   = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
          bit_cnt_d = bit_cnt_q - BW'(1);
        end else if (rep_cnt_q != '0) begin
          rep_cnt_d = rep_cnt_q - CNT_W'(1);
          if (GAP_CYC == 0) begin
            shreg_d   = pat_q;
            bit_cnt_d = BIT_LAST;
          end else begin
            gap_cnt_d = GAP_LOAD;
            state_d   = ST_GAP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end else begin
          shreg_d   = pat_q;
          bit_cnt_d = BIT_LAST;
          state_d   = ST_SHIFT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are derived from the next state so they appear registered in the
  // same cycle the state they describe becomes current.
  always_comb begin
    valid_d = (state_d == ST_SHIFT);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_q == ST_SHIFT) && (state_d == ST_IDLE);
    frame_d = valid_d && (bit_cnt_d == BIT_LAST);
    dout_d  = valid_d && shreg_d[WIDTH-1];
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = valid_q;
  assign frame_o      = frame_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx
//   Directed bench for seq_pattern_tx. Two instances share the inputs: one
//   with a one-cycle gap between repetitions, one back-to-back. Outputs are
//   compared as a packed vector {busy, done, valid, frame, dout} one time
//   unit after each rising edge.

module tb_seq_pattern_tx;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       pat_sel;
  logic [3:0] pat_in;
  logic [3:0] repeat_n;

  logic g1_dout, g1_valid, g1_frame, g1_busy, g1_done;
  logic g0_dout, g0_valid, g0_frame, g0_busy, g0_done;

  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0] det_sh;
  int         det_hits;
  logic       det_en;

  seq_pattern_tx #(.WIDTH(4), .PATTERN(4'b1011), .CNT_W(4), .GAP_CYC(1)) u_dut_gap1 (
    .clk_i(clk), .reset_ni(reset_n), .start_i(start), .pat_sel_i(pat_sel),
    .pat_in_i(pat_in), .repeat_n_i(repeat_n),
    .dout_o(g1_dout), .dout_valid_o(g1_valid), .frame_o(g1_frame),
    .busy_o(g1_busy), .done_o(g1_done)
  );

  seq_pattern_tx #(.WIDTH(4), .PATTERN(4'b1011), .CNT_W(4), .GAP_CYC(0)) u_dut_gap0 (
    .clk_i(clk), .reset_ni(reset_n), .start_i(start), .pat_sel_i(pat_sel),
    .pat_in_i(pat_in), .repeat_n_i(repeat_n),
    .dout_o(g0_dout), .dout_valid_o(g0_valid), .frame_o(g0_frame),
    .busy_o(g0_busy), .done_o(g0_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Loopback 1011 detector on the gap-1 instance's valid bits
  always @(negedge clk) begin
    if (det_en && g1_valid) begin
      det_sh <= {det_sh[2:0], g1_dout};
      if ({det_sh[2:0], g1_dout} == 4'b1011) det_hits <= det_hits + 1;
    end
  end

  function automatic logic [4:0] vec_g1();
    return {g1_busy, g1_done, g1_valid, g1_frame, g1_dout};
  endfunction

  function automatic logic [4:0] vec_g0();
    return {g0_busy, g0_done, g0_valid, g0_frame, g0_dout};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // {busy, done, valid, frame, dout}
  logic [4:0] exp_t1 [6]  = '{5'b10111, 5'b10100, 5'b10101, 5'b10101, 5'b01000, 5'b00000};
  logic [4:0] exp_t2 [16] = '{5'b10110, 5'b10101, 5'b10101, 5'b10100, 5'b10000,
                              5'b10110, 5'b10101, 5'b10101, 5'b10100, 5'b10000,
                              5'b10110, 5'b10101, 5'b10101, 5'b10100, 5'b01000,
                              5'b00000};
  logic [4:0] exp_t3 [10] = '{5'b10111, 5'b10100, 5'b10101, 5'b10101,
                              5'b10111, 5'b10100, 5'b10101, 5'b10101,
                              5'b01000, 5'b00000};
  logic [4:0] exp_xfer [5] = '{5'b10111, 5'b10100, 5'b10101, 5'b10101, 5'b01000};

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    pat_sel  = 1'b0;
    pat_in   = 4'b0000;
    repeat_n = 4'd0;
    det_en   = 1'b0;
    det_sh   = 4'b0000;
    det_hits = 0;

    // Reset state
    #1;
    chk("reset_g1", 32'(vec_g1()), 32'h0);
    chk("reset_g0", 32'(vec_g0()), 32'h0);
    #11;
    reset_n = 1'b1;
    step();
    chk("post_reset_idle", 32'(vec_g1()), 32'h0);

    // 1: default pattern, single repetition
    start = 1'b1; pat_sel = 1'b0; repeat_n = 4'd0;
    step();
    start = 1'b0;
    chk("t1_default", 32'(vec_g1()), 32'(exp_t1[0]));
    for (int i = 1; i < 6; i++) begin
      step();
      chk($sformatf("t1_default_c%0d", i), 32'(vec_g1()), 32'(exp_t1[i]));
    end

    // 2: runtime pattern 0110, three repetitions with a one-cycle gap
    start = 1'b1; pat_sel = 1'b1; pat_in = 4'b0110; repeat_n = 4'd2;
    step();
    start = 1'b0; pat_in = 4'b0000; repeat_n = 4'd0; pat_sel = 1'b0;
    chk("t2_gap", 32'(vec_g1()), 32'(exp_t2[0]));
    for (int i = 1; i < 16; i++) begin
      step();
      chk($sformatf("t2_gap_c%0d", i), 32'(vec_g1()), 32'(exp_t2[i]));
    end

    // 3: back-to-back repetitions on the gap-0 instance
    start = 1'b1; pat_sel = 1'b0; repeat_n = 4'd1;
    step();
    start = 1'b0; repeat_n = 4'd0;
    chk("t3_nogap", 32'(vec_g0()), 32'(exp_t3[0]));
    for (int i = 1; i < 10; i++) begin
      step();
      chk($sformatf("t3_nogap_c%0d", i), 32'(vec_g0()), 32'(exp_t3[i]));
    end
    step();
    step();
    chk("t3_g1_idle", 32'(vec_g1()), 32'h0);

    // 4: start and pat_in disturbed mid-transfer
    start = 1'b1; pat_sel = 1'b1; pat_in = 4'b0110; repeat_n = 4'd0;
    step();
    start = 1'b0;
    chk("t4_b0", 32'(vec_g1()), 32'b10110);
    step();
    chk("t4_b1", 32'(vec_g1()), 32'b10101);
    step();
    chk("t4_b2", 32'(vec_g1()), 32'b10101);
    start = 1'b1; pat_in = 4'b1111; repeat_n = 4'd3;
    step();
    start = 1'b0;
    chk("t4_b3", 32'(vec_g1()), 32'b10100);
    step();
    chk("t4_done", 32'(vec_g1()), 32'b01000);
    step();
    chk("t4_no_restart", 32'(vec_g1()), 32'h0);
    pat_sel = 1'b0; repeat_n = 4'd0;

    // 5: asynchronous reset mid-cycle during bit 2
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("t5_b2", 32'(vec_g1()), 32'b10101);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_async_g1", 32'(vec_g1()), 32'h0);
    chk("t5_async_g0", 32'(vec_g0()), 32'h0);
    step();
    chk("t5_held", 32'(vec_g1()), 32'h0);
    reset_n = 1'b1;
    step();
    chk("t5_no_done", 32'(vec_g1()), 32'h0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_restart", 32'(vec_g1()), 32'(exp_xfer[0]));
    for (int i = 1; i < 5; i++) begin
      step();
      chk($sformatf("t5_restart_c%0d", i), 32'(vec_g1()), 32'(exp_xfer[i]));
    end
    step();
    chk("t5_idle", 32'(vec_g1()), 32'h0);

    // 6: start held high over three transfers, loopback detector
    det_en = 1'b1;
    start  = 1'b1;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 5; i++) begin
        step();
        chk($sformatf("t6_x%0d_c%0d", t, i), 32'(vec_g1()), 32'(exp_xfer[i]));
      end
    end
    start = 1'b0;
    step();
    chk("t6_idle", 32'(vec_g1()), 32'h0);
    det_en = 1'b0;
    step();
    chk("t6_detect_hits", 32'(det_hits), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter that drives a 1-bit stream for the team's serial pattern detectors. On a start request it latches a WIDTH-bit pattern, either the built-in default 1011 or a runtime value, and a repeat count. It shifts the pattern out MSB-first, one bit per clock, for repeat_n+1 repetitions, with an optional idle gap between repetitions. A one-cycle done pulse marks the end of the transfer.

## Interface
- WIDTH, 4, pattern length in bits; legal range 2..16
- PATTERN, 4'b1011, default pattern; used when pat_sel=0
- CNT_W, 4, width of repeat_n and of the internal repetition counter
- GAP_CYC, 1, idle cycles inserted between repetitions; legal range 0..15, 0 = back-to-back
- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  transfer request; sampled only when idle
- pat_sel  input  1  0 = send PATTERN, 1 = send pat_in
- pat_in  input  WIDTH  runtime pattern, latched on accepted start
- repeat_n  input  CNT_W  extra repetitions, latched on accepted start; total sends = repeat_n+1
- dout  output  1  serial data; 0 whenever dout_valid=0
- dout_valid  output  1  dout carries a pattern bit this cycle
- frame  output  1  high with the MSB of each repetition
- busy  output  1  transfer in progress
- done  output  1  one-cycle pulse at transfer end

## Operation
- Registers: WIDTH-bit shift register, bit counter, CNT_W repetition counter, gap counter, latched pattern copy for reloads. All outputs are registered.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - start=1 at an edge: latch the selected pattern and repeat_n, load the shift register, go to SHIFT.
  - Outputs after that edge: busy=1, dout_valid=1, frame=1, dout=pattern[WIDTH-1].
- SHIFT:
  - Each edge advances one bit, MSB first. frame=0 except on the MSB.
  - After bit 0:
    - If the repetition counter is nonzero, decrement it.
      - GAP_CYC>0: go to GAP.
      - GAP_CYC=0: reload the latched pattern and stay in SHIFT with frame=1.
    - If the counter is zero: go to IDLE, busy=0, done=1 for one cycle.
- GAP:
  - dout=0, dout_valid=0, frame=0, busy=1 for exactly GAP_CYC cycles.
  - Then reload the latched pattern and go to SHIFT, MSB presented with frame=1.
- start while busy=1 is ignored; it is neither queued nor counted.
- pat_sel, pat_in and repeat_n are don't-care except on the accepting edge. Changes mid-transfer have no effect.
- The done cycle is an IDLE cycle. A start sampled at the edge ending the done cycle is accepted normally.

## Timing
- Reset asserted, at any time: immediately dout=0, dout_valid=0, frame=0, busy=0, done=0, state IDLE, all counters 0.
  - An in-flight transfer is aborted with no done pulse.
  - The first edge after deassertion may accept start.
- Latency: start sampled at edge E0 -> MSB valid from E0 to E1.
- Bit k (k=0 MSB) of repetition r (r=0 first) is valid after edge E0 + r*(WIDTH+GAP_CYC) + k.
- Total busy cycles = (repeat_n+1)*WIDTH + repeat_n*GAP_CYC.
- done is high during the single cycle after the last bit.
- With start held high continuously, consecutive transfers are separated by exactly one idle cycle: the done cycle.
- repeat_n is at most 2^CNT_W-1. The repetition counter never wraps; it stops at 0.

## Test plan
- Default pattern, pat_sel=0, repeat_n=0, start pulse at E0:
  - dout_valid=1 for 4 cycles, dout=1,0,1,1.
  - frame on the first bit only.
  - busy 4 cycles, done=1 in cycle 5, then all outputs 0.
- pat_sel=1, pat_in=4'b0110, repeat_n=2, GAP_CYC=1:
  - Stream 0110,gap,0110,gap,0110.
  - busy=14 cycles, 3 frame pulses, 1 done pulse.
  - dout=0 in both gap cycles.
- GAP_CYC=0, repeat_n=1, default pattern:
  - dout_valid continuous for 8 cycles, dout=10111011.
  - frame high in cycles 1 and 5.
- start pulsed at bit 2 of a transfer; pat_in changed from 0110 to 1111 mid-transfer:
  - The output stream is unchanged and no second transfer starts.
- Reset asserted asynchronously, mid-cycle, during bit 2:
  - All outputs 0 immediately, no done.
  - After release, a new start sends the full pattern from the MSB.
- start held high over 3 transfers:
  - Each transfer is separated by exactly one cycle with done=1 and dout_valid=0.
  - Every transfer contains a correct 1011.
  - A loopback into a 1011 detector flags each occurrence.
